// File: rtl/dmem_wait_ctrl.sv
// Word-addressed data RAM with byte-lane writes, req/ready handshake and a
// programmable wait-state counter. Define DMEM_PARITY_EN for per-lane even parity.
module dmem_wait_ctrl #(
  parameter  int unsigned DATA_W      = 32,
  parameter  int unsigned DEPTH       = 32,
  parameter  int unsigned WAIT_STATES = 0,
  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned NB          = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     be,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_err,
`ifdef DMEM_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_be;
  logic              r_done;
  logic              r_addr_err;
  logic [DATA_W-1:0] r_rdata;

  logic w_fire;
  logic w_accept;
  logic w_in_range;
  logic w_dbg_ok;

  // The completing cycle also accepts, so back-to-back accesses never idle.
  assign w_fire     = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign ready      = (r_state == S_IDLE) || w_fire;
  assign w_accept   = req && ready;
  assign w_in_range = 32'(r_addr) < DEPTH;
  assign w_dbg_ok   = 32'(dbg_addr) < DEPTH;

  assign done     = r_done;
  assign addr_err = r_addr_err;
  assign rdata    = r_rdata;
  assign dbg_data = w_dbg_ok ? r_mem[dbg_addr] : '0;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic          r_inj;
  logic          r_par_err;
  logic          w_par_mis;

  assign par_err = r_par_err;

  always_comb begin
    w_par_mis = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      w_par_mis = w_par_mis | ((^r_mem[r_addr][8*i +: 8]) ^ r_par[r_addr][i]);
    end
  end
`endif

  // Array storage carries no reset; only a completing in-range write touches it.
  always_ff @(posedge clk) begin
    if (w_fire && r_we && w_in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (r_be[i]) begin
          r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
`ifdef DMEM_PARITY_EN
          r_par[r_addr][i] <= (^r_wdata[8*i +: 8]) ^ r_inj;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_done     <= 1'b0;
      r_addr_err <= 1'b0;
      r_rdata    <= '0;
`ifdef DMEM_PARITY_EN
      r_inj      <= 1'b0;
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_done     <= w_fire;
      r_addr_err <= w_fire && !w_in_range;
      if (w_fire && !r_we) begin
        r_rdata <= w_in_range ? r_mem[r_addr] : '0;
      end
`ifdef DMEM_PARITY_EN
      if (w_fire && !r_we && w_in_range && w_par_mis) begin
        r_par_err <= 1'b1;
      end
`endif
      if (w_accept) begin
        r_state <= S_BUSY;
        r_cnt   <= 4'(WAIT_STATES);
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_be    <= be;
`ifdef DMEM_PARITY_EN
        r_inj   <= par_inj;
`endif
      end else if (w_fire) begin
        r_state <= S_IDLE;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Scoreboard bench for dmem_wait_ctrl (DEPTH=20, WAIT_STATES=2).
module tb_dmem_wait_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 20;
  localparam int unsigned WS    = 2;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    be = '0;
  logic          ready;
  logic          done;
  logic [DW-1:0] rdata;
  logic          addr_err;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
`ifdef DMEM_PARITY_EN
  logic          par_inj = 1'b0;
  logic          par_err;
`endif

  dmem_wait_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .done(done), .rdata(rdata), .addr_err(addr_err),
`ifdef DMEM_PARITY_EN
    .par_inj(par_inj), .par_err(par_err),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          aerr;
    int            cyc;
  } cmp_t;

  cmp_t          exp_q[$];
  cmp_t          got_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] m_rdata = '0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done === 1'b1) got_q.push_back('{rdata, addr_err, cyc});
  end

  // Drive one request, hold it until accepted, and predict its completion.
  task automatic issue(input logic iwe, input logic [AW-1:0] ia,
                       input logic [DW-1:0] iwd, input logic [3:0] ibe);
    int   n = 0;
    cmp_t e;
    req = 1'b1; we = iwe; addr = ia; wdata = iwd; be = ibe;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      n_checks++;
      $display("FAIL issue_timeout ready=%b required 1", ready);
    end
    @(posedge clk); #1;
    req = 1'b0;
`ifdef DMEM_PARITY_EN
    par_inj = 1'b0;
`endif
    if (32'(ia) < DEPTH) begin
      if (iwe) begin
        for (int i = 0; i < 4; i++) if (ibe[i]) model[ia][8*i +: 8] = iwd[8*i +: 8];
      end else begin
        m_rdata = model[ia];
      end
    end else if (!iwe) begin
      m_rdata = '0;
    end
    e.rdata = m_rdata;
    e.aerr  = (32'(ia) >= DEPTH);
    e.cyc   = cyc + int'(WS) + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (n >= 100) begin
      n_checks++;
      $display("FAIL drain_timeout got=%0d required=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err got=%b exp=0", addr_err); else n_pass++;
    n_checks++; if (rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", rdata); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    cmp_t e, g;
    issue(1'b1, 5'd3, 32'h0800_0000, 4'hF);
    issue(1'b0, 5'd3, '0, 4'h0);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin $display("FAIL wr_rd_missing_done exp_rdata=%h", e.rdata); continue; end
      g = got_q.pop_front();
      if (g.rdata !== e.rdata || g.aerr !== e.aerr || g.cyc != e.cyc)
        $display("FAIL wr_rd got=%h/%b@%0d exp=%h/%b@%0d", g.rdata, g.aerr, g.cyc, e.rdata, e.aerr, e.cyc);
      else n_pass++;
    end
    n_checks++; if (got_q.size() != 0) $display("FAIL wr_rd_extra_done got=%0d exp=0", got_q.size()); else n_pass++;
    n_checks++; if (rdata !== 32'h0800_0000) $display("FAIL wr_rd_value got=%h exp=08000000", rdata); else n_pass++;
  endtask

  task automatic test_wait_states();
    cmp_t e, g;
    issue(1'b0, 5'd3, '0, 4'h0);
    n_checks++; if (ready !== 1'b0) $display("FAIL ws_ready_c0 got=%b exp=0", ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b0) $display("FAIL ws_ready_c1 got=%b exp=0", ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL ws_fire_cycle ready=%b done=%b exp 1/0", ready, done); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) $display("FAIL ws_done got=%b exp=1", done); else n_pass++;
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin $display("FAIL ws_missing_done exp_rdata=%h", e.rdata); continue; end
      g = got_q.pop_front();
      if (g.rdata !== e.rdata || g.aerr !== e.aerr || g.cyc != e.cyc)
        $display("FAIL ws got=%h/%b@%0d exp=%h/%b@%0d", g.rdata, g.aerr, g.cyc, e.rdata, e.aerr, e.cyc);
      else n_pass++;
    end
  endtask

  task automatic test_byte_lanes();
    cmp_t e, g;
    issue(1'b1, 5'd9, 32'hFFFF_FFFF, 4'hF);
    issue(1'b1, 5'd9, 32'h0000_0000, 4'b0101);
    issue(1'b1, 5'd9, 32'h1234_5678, 4'b0000);
    issue(1'b0, 5'd9, '0, 4'h0);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin $display("FAIL lanes_missing_done exp_rdata=%h", e.rdata); continue; end
      g = got_q.pop_front();
      if (g.rdata !== e.rdata || g.aerr !== e.aerr || g.cyc != e.cyc)
        $display("FAIL lanes got=%h/%b@%0d exp=%h/%b@%0d", g.rdata, g.aerr, g.cyc, e.rdata, e.aerr, e.cyc);
      else n_pass++;
    end
    n_checks++; if (rdata !== 32'hFF00_FF00) $display("FAIL lanes_value got=%h exp=ff00ff00", rdata); else n_pass++;
  endtask

  task automatic test_addr_err();
    cmp_t e, g;
    issue(1'b1, 5'd25, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 5'd25, '0, 4'h0);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin $display("FAIL oor_missing_done exp_rdata=%h", e.rdata); continue; end
      g = got_q.pop_front();
      if (g.rdata !== e.rdata || g.aerr !== e.aerr || g.cyc != e.cyc)
        $display("FAIL oor got=%h/%b@%0d exp=%h/%b@%0d", g.rdata, g.aerr, g.cyc, e.rdata, e.aerr, e.cyc);
      else n_pass++;
    end
    dbg_addr = 5'd25; #1;
    n_checks++; if (dbg_data !== '0) $display("FAIL dbg_oor got=%h exp=0", dbg_data); else n_pass++;
    dbg_addr = 5'd9; #1;
    n_checks++; if (dbg_data !== model[9]) $display("FAIL dbg_in_range got=%h exp=%h", dbg_data, model[9]); else n_pass++;
  endtask

  task automatic test_simultaneous();
    issue(1'b1, 5'd4, 32'h1111_1111, 4'hF);
    wait_drain();
    exp_q.delete(); got_q.delete();
    dbg_addr = 5'd4;
    issue(1'b1, 5'd4, 32'h2222_2222, 4'hF);
    repeat (WS) @(posedge clk);
    #1;
    n_checks++; if (dbg_data !== 32'h1111_1111) $display("FAIL dbg_old got=%h exp=11111111", dbg_data); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (dbg_data !== 32'h2222_2222) $display("FAIL dbg_new got=%h exp=22222222", dbg_data); else n_pass++;
    wait_drain();
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    cmp_t          e, g;
    logic [DW-1:0] old5;
    issue(1'b1, 5'd5, 32'hCAFE_0005, 4'hF);
    issue(1'b0, 5'd5, '0, 4'h0);
    wait_drain();
    exp_q.delete(); got_q.delete();
    old5 = model[5];
    issue(1'b1, 5'd5, 32'h0BAD_F00D, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_checks++; if (done !== 1'b0 || rdata !== '0) $display("FAIL rst_mid_out done=%b rdata=%h exp 0/0", done, rdata); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL rst_mid_idle ready=%b exp=1", ready); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model[5] = old5; m_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete(); got_q.delete();
    dbg_addr = 5'd5; #1;
    n_checks++; if (dbg_data !== 32'hCAFE_0005) $display("FAIL rst_mid_mem got=%h exp=cafe0005", dbg_data); else n_pass++;
    issue(1'b0, 5'd5, '0, 4'h0);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin $display("FAIL rst_mid_missing_done exp_rdata=%h", e.rdata); continue; end
      g = got_q.pop_front();
      if (g.rdata !== e.rdata || g.aerr !== e.aerr || g.cyc != e.cyc)
        $display("FAIL rst_mid_read got=%h/%b@%0d exp=%h/%b@%0d", g.rdata, g.aerr, g.cyc, e.rdata, e.aerr, e.cyc);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    cmp_t e, g;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 5'(10 + i), $urandom, 4'($urandom_range(1, 15)));
      issue(1'b0, 5'(10 + ((i * 7) % 6)), '0, 4'h0);
    end
    issue(1'b0, 5'd19, '0, 4'h0);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin $display("FAIL b2b_missing_done exp_rdata=%h", e.rdata); continue; end
      g = got_q.pop_front();
      if (g.rdata !== e.rdata || g.aerr !== e.aerr || g.cyc != e.cyc)
        $display("FAIL b2b got=%h/%b@%0d exp=%h/%b@%0d", g.rdata, g.aerr, g.cyc, e.rdata, e.aerr, e.cyc);
      else n_pass++;
    end
    n_checks++; if (got_q.size() != 0) $display("FAIL b2b_extra_done got=%0d exp=0", got_q.size()); else n_pass++;
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    n_checks++; if (par_err !== 1'b0) $display("FAIL par_clean got=%b exp=0", par_err); else n_pass++;
    par_inj = 1'b1;
    issue(1'b1, 5'd7, 32'h0102_0304, 4'hF);
    issue(1'b0, 5'd7, '0, 4'h0);
    wait_drain();
    n_checks++; if (par_err !== 1'b1) $display("FAIL par_set got=%b exp=1", par_err); else n_pass++;
    issue(1'b1, 5'd8, 32'hA5A5_0001, 4'hF);
    issue(1'b0, 5'd8, '0, 4'h0);
    wait_drain();
    n_checks++; if (par_err !== 1'b1) $display("FAIL par_sticky got=%b exp=1", par_err); else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++; if (par_err !== 1'b0) $display("FAIL par_reset got=%b exp=0", par_err); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1; m_rdata = '0;
    exp_q.delete(); got_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_byte_lanes();
    test_addr_err();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
